fetch_sequencer: RTL and testbench

Instruction fetch control stage sitting directly upstream of the loadable program counter. It drives the counter's enable/count_up/load/load_value inputs and consumes its counter_value as the fetch address. It issues requests to instruction memory and presents each fetched word to decode over a valid/ready handshake. It also applies branch redirects and the boot vector by loading the counter.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_sequencer.sv | 160 ++++++++++++++++
 tb/tb_fetch_sequencer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer.
//   fetch_state_t : sequencer FSM encoding (also visible on the debug port)
//   *_DEF         : default widths for the PC and the instruction word
package fetch_pkg;

    localparam int ADDR_WIDTH_DEF  = 8;
    localparam int INSTR_WIDTH_DEF = 16;

    typedef enum logic [2:0] {
        BOOT   = 3'd0,
        FETCH  = 3'd1,
        HOLD   = 3'd2,
        FLUSH  = 3'd3,
        HALTED = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction fetch control stage in front of a loadable program counter.
// Drives the counter (enable / count_up / load / load_value), reads the
// current PC back as the fetch address, requests instruction words from
// memory and hands each word to decode.
//
// Ports:
//   clock, reset              rising-edge clock, synchronous active-high reset
//   pc_value                  current counter value (fetch address)
//   pc_enable/pc_count_up/
//   pc_load/pc_load_value     counter controls (combinational)
//   mem_req/mem_addr          memory read request (combinational)
//   mem_ready/mem_rdata       memory read completion and data
//   instr_valid/instr_ready/
//   instr_data/instr_pc       fetched word to decode (registered)
//   redirect_valid/target     taken branch / jump, one-cycle pulse
//   halt                      level, stop issuing new fetches
//   dbg_state                 current FSM state
//
// Handshake: a word moves to decode in any cycle where instr_valid and
// instr_ready are both 1; instr_data/instr_pc stay stable while instr_valid
// is 1 and instr_ready is 0. On the memory side a read completes in a cycle
// where mem_req and mem_ready are both 1; dropping mem_req abandons it.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int                    INSTR_WIDTH  = INSTR_WIDTH_DEF,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [ADDR_WIDTH-1:0]  pc_value,
    output logic                   pc_enable,
    output logic                   pc_count_up,
    output logic                   pc_load,
    output logic [ADDR_WIDTH-1:0]  pc_load_value,
    output logic                   mem_req,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic                   mem_ready,
    input  logic [INSTR_WIDTH-1:0] mem_rdata,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0]  instr_pc,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_target,
    input  logic                   halt,
    output fetch_state_t           dbg_state
);

    fetch_state_t           state_q, state_d;
    logic                   instr_valid_q, instr_valid_d;
    logic [INSTR_WIDTH-1:0] instr_data_q, instr_data_d;
    logic [ADDR_WIDTH-1:0]  instr_pc_q, instr_pc_d;

    logic                   redirect;
    logic                   count_up_c;
    logic                   load_c;
    logic [ADDR_WIDTH-1:0]  load_value_c;
    logic                   req_c;

    always_comb begin
        state_d       = state_q;
        instr_valid_d = instr_valid_q;
        instr_data_d  = instr_data_q;
        instr_pc_d    = instr_pc_q;
        count_up_c    = 1'b0;
        load_c        = 1'b0;
        load_value_c  = '0;
        req_c         = 1'b0;
        // The boot load must not be overridden, so redirects wait for FETCH.
        redirect      = redirect_valid && (state_q != BOOT);

        case (state_q)
            BOOT: begin
                load_c       = 1'b1;
                load_value_c = RESET_VECTOR;
                state_d      = FETCH;
            end
            FETCH: begin
                if (halt) begin
                    state_d = HALTED;
                end else begin
                    req_c = 1'b1;
                    if (mem_ready) begin
                        instr_valid_d = 1'b1;
                        instr_data_d  = mem_rdata;
                        instr_pc_d    = pc_value;
                        count_up_c    = 1'b1;
                        state_d       = HOLD;
                    end
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    instr_valid_d = 1'b0;
                    state_d       = halt ? HALTED : FETCH;
                end
            end
            FLUSH: begin
                // Counter already holds the target; just one idle cycle.
                state_d = halt ? HALTED : FETCH;
            end
            HALTED: begin
                if (!halt) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        // Redirect wins over any same-cycle fetch completion: the counter
        // prefers count_up over load, so the increment must be suppressed,
        // and the word fetched from the old path is thrown away.
        if (redirect) begin
            load_c        = 1'b1;
            load_value_c  = redirect_target;
            count_up_c    = 1'b0;
            instr_valid_d = 1'b0;
            instr_data_d  = instr_data_q;
            instr_pc_d    = instr_pc_q;
            state_d       = FLUSH;
        end

        if (reset) begin
            count_up_c   = 1'b0;
            load_c       = 1'b0;
            load_value_c = '0;
            req_c        = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= BOOT;
            instr_valid_q <= 1'b0;
            instr_data_q  <= '0;
            instr_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            instr_valid_q <= instr_valid_d;
            instr_data_q  <= instr_data_d;
            instr_pc_q    <= instr_pc_d;
        end
    end

    assign pc_count_up   = count_up_c;
    assign pc_load       = load_c;
    assign pc_load_value = load_value_c;
    assign pc_enable     = count_up_c | load_c;
    assign mem_req       = req_c;
    assign mem_addr      = req_c ? pc_value : '0;
    assign instr_valid   = instr_valid_q;
    assign instr_data    = instr_data_q;
    assign instr_pc      = instr_pc_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;
    import fetch_pkg::*;

    localparam int AW = 8;
    localparam int IW = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic [AW-1:0] pc_value;
    logic          pc_enable, pc_count_up, pc_load;
    logic [AW-1:0] pc_load_value;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ready;
    logic [IW-1:0] mem_rdata;
    logic          instr_valid, instr_ready;
    logic [IW-1:0] instr_data;
    logic [AW-1:0] instr_pc;
    logic          redirect_valid;
    logic [AW-1:0] redirect_target;
    logic          halt;
    fetch_state_t  dbg_state;

    int checks = 0;
    int failures = 0;

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    fetch_sequencer #(
        .ADDR_WIDTH   (AW),
        .INSTR_WIDTH  (IW),
        .RESET_VECTOR (8'h10)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .pc_value        (pc_value),
        .pc_enable       (pc_enable),
        .pc_count_up     (pc_count_up),
        .pc_load         (pc_load),
        .pc_load_value   (pc_load_value),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_ready       (mem_ready),
        .mem_rdata       (mem_rdata),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr_data      (instr_data),
        .instr_pc        (instr_pc),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt            (halt),
        .dbg_state       (dbg_state)
    );

    // Loadable program counter: reset to 0, count_up has priority over load.
    logic [AW-1:0] pc_q;
    always_ff @(posedge clock) begin
        if (reset) pc_q <= '0;
        else if (pc_enable) begin
            if (pc_count_up) pc_q <= pc_q + 8'd1;
            else if (pc_load) pc_q <= pc_load_value;
        end
    end
    assign pc_value = pc_q;

    // ---------------- vector table ----------------
    typedef struct {
        logic          rst, mrdy;
        logic [IW-1:0] rdata;
        logic          irdy, rdv;
        logic [AW-1:0] rtgt;
        logic          hlt;
        fetch_state_t  st;
        logic [AW-1:0] pc;
        logic          en, cu, ld;
        logic [AW-1:0] lv;
        logic          req;
        logic [AW-1:0] addr;
        logic          iv;
        logic [AW-1:0] ipc;
        logic [IW-1:0] idata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(
        input logic rst, input logic mrdy, input logic [IW-1:0] rdata,
        input logic irdy, input logic rdv, input logic [AW-1:0] rtgt,
        input logic hlt, input fetch_state_t st, input logic [AW-1:0] pc,
        input logic en, input logic cu, input logic ld, input logic [AW-1:0] lv,
        input logic req, input logic [AW-1:0] addr,
        input logic iv, input logic [AW-1:0] ipc, input logic [IW-1:0] idata);
        vec_t r;
        r.rst = rst; r.mrdy = mrdy; r.rdata = rdata; r.irdy = irdy;
        r.rdv = rdv; r.rtgt = rtgt; r.hlt = hlt; r.st = st; r.pc = pc;
        r.en = en; r.cu = cu; r.ld = ld; r.lv = lv; r.req = req;
        r.addr = addr; r.iv = iv; r.ipc = ipc; r.idata = idata;
        return r;
    endfunction

    // ---------------- driver / scoreboard helpers ----------------
    task automatic drive(input logic rst, input logic mrdy, input logic [IW-1:0] rdata,
                         input logic irdy, input logic rdv, input logic [AW-1:0] rtgt,
                         input logic hlt);
        reset = rst; mem_ready = mrdy; mem_rdata = rdata; instr_ready = irdy;
        redirect_valid = rdv; redirect_target = rtgt; halt = hlt;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    int cu_pulses;
    int req_cycles;
    bit seen;

    initial begin
        drive(1, 0, '0, 0, 0, '0, 0);
        repeat (2) @(posedge clock);
        #1;

        //        rst mr rdata    ir rv tgt    h  state   pc     en cu ld lv     rq addr   iv ipc    idata
        vecs.push_back(v(1, 0, 16'h0000, 0, 0, 8'h00, 0, BOOT,   8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 16'h0000));
        vecs.push_back(v(0, 0, 16'h0000, 0, 0, 8'h00, 0, BOOT,   8'h00, 1, 0, 1, 8'h10, 0, 8'h00, 0, 8'h00, 16'h0000));
        vecs.push_back(v(0, 1, 16'hA010, 1, 0, 8'h00, 0, FETCH,  8'h10, 1, 1, 0, 8'h00, 1, 8'h10, 0, 8'h00, 16'h0000));
        vecs.push_back(v(0, 1, 16'h0000, 1, 0, 8'h00, 0, HOLD,   8'h11, 0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h10, 16'hA010));
        vecs.push_back(v(0, 1, 16'hA011, 0, 0, 8'h00, 0, FETCH,  8'h11, 1, 1, 0, 8'h00, 1, 8'h11, 0, 8'h00, 16'h0000));
        vecs.push_back(v(0, 0, 16'h0000, 1, 0, 8'h00, 0, HOLD,   8'h12, 0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h11, 16'hA011));
        vecs.push_back(v(0, 1, 16'hA012, 0, 0, 8'h00, 0, FETCH,  8'h12, 1, 1, 0, 8'h00, 1, 8'h12, 0, 8'h00, 16'h0000));
        // decode backpressure for four cycles
        for (int k = 0; k < 4; k++)
            vecs.push_back(v(0, 0, 16'h0000, (k == 3), 0, 8'h00, 0, HOLD, 8'h13, 0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h12, 16'hA012));
        // three-cycle memory latency
        vecs.push_back(v(0, 0, 16'h0000, 0, 0, 8'h00, 0, FETCH,  8'h13, 0, 0, 0, 8'h00, 1, 8'h13, 0, 8'h00, 16'h0000));
        vecs.push_back(v(0, 0, 16'h0000, 0, 0, 8'h00, 0, FETCH,  8'h13, 0, 0, 0, 8'h00, 1, 8'h13, 0, 8'h00, 16'h0000));
        vecs.push_back(v(0, 1, 16'hB013, 0, 0, 8'h00, 0, FETCH,  8'h13, 1, 1, 0, 8'h00, 1, 8'h13, 0, 8'h00, 16'h0000));
        // redirect while the held word is accepted
        vecs.push_back(v(0, 0, 16'h0000, 1, 1, 8'h25, 0, HOLD,   8'h14, 1, 0, 1, 8'h25, 0, 8'h00, 1, 8'h13, 16'hB013));
        vecs.push_back(v(0, 0, 16'h0000, 0, 0, 8'h00, 0, FLUSH,  8'h25, 0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 16'h0000));
        // redirect coincident with mem_ready: data discarded, no increment
        vecs.push_back(v(0, 1, 16'hDEAD, 0, 1, 8'h40, 0, FETCH,  8'h25, 1, 0, 1, 8'h40, 1, 8'h25, 0, 8'h00, 16'h0000));
        vecs.push_back(v(0, 0, 16'h0000, 0, 0, 8'h00, 0, FLUSH,  8'h40, 0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 16'h0000));
        vecs.push_back(v(0, 1, 16'hC040, 0, 0, 8'h00, 0, FETCH,  8'h40, 1, 1, 0, 8'h00, 1, 8'h40, 0, 8'h00, 16'h0000));
        // accept with halt -> HALTED, release, halt again mid-FETCH
        vecs.push_back(v(0, 0, 16'h0000, 1, 0, 8'h00, 1, HOLD,   8'h41, 0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h40, 16'hC040));
        vecs.push_back(v(0, 0, 16'h0000, 0, 0, 8'h00, 1, HALTED, 8'h41, 0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 16'h0000));
        vecs.push_back(v(0, 0, 16'h0000, 0, 0, 8'h00, 0, HALTED, 8'h41, 0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 16'h0000));
        vecs.push_back(v(0, 0, 16'h0000, 0, 0, 8'h00, 0, FETCH,  8'h41, 0, 0, 0, 8'h00, 1, 8'h41, 0, 8'h00, 16'h0000));
        vecs.push_back(v(0, 1, 16'hEEEE, 0, 0, 8'h00, 1, FETCH,  8'h41, 0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 16'h0000));
        vecs.push_back(v(0, 0, 16'h0000, 0, 0, 8'h00, 0, HALTED, 8'h41, 0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 16'h0000));
        vecs.push_back(v(0, 1, 16'h0041, 0, 0, 8'h00, 0, FETCH,  8'h41, 1, 1, 0, 8'h00, 1, 8'h41, 0, 8'h00, 16'h0000));
        // redirect to FF while holding an unaccepted word, then wrap
        vecs.push_back(v(0, 0, 16'h0000, 0, 1, 8'hFF, 0, HOLD,   8'h42, 1, 0, 1, 8'hFF, 0, 8'h00, 1, 8'h41, 16'h0041));
        vecs.push_back(v(0, 0, 16'h0000, 0, 0, 8'h00, 0, FLUSH,  8'hFF, 0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 16'h0000));
        vecs.push_back(v(0, 1, 16'hF0FF, 0, 0, 8'h00, 0, FETCH,  8'hFF, 1, 1, 0, 8'h00, 1, 8'hFF, 0, 8'h00, 16'h0000));
        vecs.push_back(v(0, 0, 16'h0000, 0, 0, 8'h00, 0, HOLD,   8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 1, 8'hFF, 16'hF0FF));
        // reset in HOLD, then boot again with a redirect that must be ignored
        vecs.push_back(v(1, 0, 16'h0000, 1, 1, 8'h33, 0, HOLD,   8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 1, 8'hFF, 16'hF0FF));
        vecs.push_back(v(0, 0, 16'h0000, 0, 1, 8'h77, 0, BOOT,   8'h00, 1, 0, 1, 8'h10, 0, 8'h00, 0, 8'h00, 16'h0000));
        vecs.push_back(v(0, 1, 16'h1234, 0, 0, 8'h00, 0, FETCH,  8'h10, 1, 1, 0, 8'h00, 1, 8'h10, 0, 8'h00, 16'h0000));
        vecs.push_back(v(0, 0, 16'h0000, 1, 0, 8'h00, 0, HOLD,   8'h11, 0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h10, 16'h1234));

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t r;
            r = vecs[i];
            drive(r.rst, r.mrdy, r.rdata, r.irdy, r.rdv, r.rtgt, r.hlt);
            @(negedge clock);
            chk($sformatf("r%0d state", i), 32'(dbg_state), 32'(r.st));
            chk($sformatf("r%0d pc_value", i), 32'(pc_value), 32'(r.pc));
            chk($sformatf("r%0d pc_enable", i), 32'(pc_enable), 32'(r.en));
            chk($sformatf("r%0d pc_count_up", i), 32'(pc_count_up), 32'(r.cu));
            chk($sformatf("r%0d pc_load", i), 32'(pc_load), 32'(r.ld));
            chk($sformatf("r%0d up_and_load", i), 32'(pc_count_up & pc_load), 32'd0);
            if (r.ld || r.rst)
                chk($sformatf("r%0d pc_load_value", i), 32'(pc_load_value), 32'(r.lv));
            chk($sformatf("r%0d mem_req", i), 32'(mem_req), 32'(r.req));
            if (r.req)
                chk($sformatf("r%0d mem_addr", i), 32'(mem_addr), 32'(r.addr));
            chk($sformatf("r%0d instr_valid", i), 32'(instr_valid), 32'(r.iv));
            if (r.iv || r.st == BOOT) begin
                chk($sformatf("r%0d instr_pc", i), 32'(instr_pc), 32'(r.ipc));
                chk($sformatf("r%0d instr_data", i), 32'(instr_data), 32'(r.idata));
            end
            next_cycle();
        end

        // ---- redirect and halt together in FETCH (PC=11) ----
        drive(0, 1, 16'h9999, 0, 1, 8'h80, 1);
        @(negedge clock);
        chk("rh state", 32'(dbg_state), 32'(FETCH));
        chk("rh pc_load", 32'(pc_load), 32'd1);
        chk("rh pc_load_value", 32'(pc_load_value), 32'h80);
        chk("rh pc_count_up", 32'(pc_count_up), 32'd0);
        chk("rh mem_req", 32'(mem_req), 32'd0);
        next_cycle();
        drive(0, 0, '0, 0, 0, '0, 1);
        @(negedge clock);
        chk("rh flush state", 32'(dbg_state), 32'(FLUSH));
        chk("rh flush pc", 32'(pc_value), 32'h80);
        chk("rh flush valid", 32'(instr_valid), 32'd0);
        next_cycle();
        @(negedge clock);
        chk("rh halted state", 32'(dbg_state), 32'(HALTED));
        chk("rh halted mem_req", 32'(mem_req), 32'd0);
        next_cycle();
        drive(0, 0, '0, 0, 0, '0, 0);
        next_cycle();

        // ---- resume at target with a three-cycle memory latency ----
        cu_pulses = 0;
        req_cycles = 0;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            drive(0, (k == 2), 16'h5A80, 0, 0, '0, 0);
            @(negedge clock);
            if (mem_req) begin
                req_cycles++;
                chk($sformatf("lat mem_addr c%0d", k), 32'(mem_addr), 32'h80);
            end
            if (pc_count_up) cu_pulses++;
            next_cycle();
            if (instr_valid) seen = 1;
        end
        drive(0, 0, '0, 0, 0, '0, 0);
        chk("lat instr_valid seen", 32'(seen), 32'd1);
        chk("lat instr_pc", 32'(instr_pc), 32'h80);
        chk("lat instr_data", 32'(instr_data), 32'h5A80);
        chk("lat count_up pulses", 32'(cu_pulses), 32'd1);
        chk("lat mem_req cycles", 32'(req_cycles), 32'd3);
        @(negedge clock);
        chk("lat pc after fetch", 32'(pc_value), 32'h81);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
